spi_slave_mm_burst: RTL and testbench
=====================================

Name: spi_slave_mm_burst

Overview:
Second-generation SPI slave (mode 0, MSB first) that bridges to a memory-mapped bus master. It replaces the single-word slave with a parametrised version that adds:
- burst transfers with address auto-increment,
- a req/ack read handshake with prefetch,
- configurable turnaround bits,
- an underrun error pulse.

It sits between an external SPI host and the on-chip register/memory bus, in the same position as the existing SPI-to-MM bridge.

Parameters:
MM_ADDR_WIDTH, 8, width of bus address and of the SPI address field
MM_DATA_WIDTH, 16, width of bus data and of each SPI data word
DUMMY_BITS, 0, number of SCLK turnaround bits between the address field and the first read data bit (0..15)
DUMMY_DATA, 0, word shifted out when read data is not ready in time

Ports:
clk_sys_i  input  1  system clock; all logic is on the rising edge
rst_n_i  input  1  asynchronous active-low reset
spi_sclk_i  input  1  SPI clock, async, idle low
spi_mosi_i  input  1  SPI data in
spi_miso_o  output  1  SPI data out; high-Z whenever spi_cs_n_i is high (combinational from the raw pin)
spi_cs_n_i  input  1  SPI chip select, active low
mm_m_addr_o  output  MM_ADDR_WIDTH  bus address
mm_m_wdata_o  output  MM_DATA_WIDTH  bus write data
mm_m_rdata_i  input  MM_DATA_WIDTH  bus read data, valid while mm_m_ack_i is high
mm_m_we_o  output  1  write strobe, one-cycle pulse; the slave accepts in that cycle
mm_m_re_o  output  1  read request, held high until acknowledged
mm_m_ack_i  input  1  read acknowledge, one cycle
spi_err_o  output  1  one-cycle pulse on read underrun

Behaviour:
- Reset (async, any time, including mid-frame):
  - fsm = IDLE; all counters and buffers = 0; read-buffer valid = 0.
  - All outputs = 0: mm_m_addr_o, mm_m_wdata_o, mm_m_we_o, mm_m_re_o, spi_err_o, and the internal MISO register.
- Synchronisers:
  - SCLK and CS_n: 3 flops each. MOSI: 2 flops.
  - Edges are detected on sync stages [2:1]; rise = 01, fall = 10.
  - Required: f_sclk <= f_clk_sys/8.
- Frame format:
  - 1 RW bit (1 = read), then MM_ADDR_WIDTH address bits, then data words of MM_DATA_WIDTH bits each.
  - Burst continues until CS_n rises.
- CS_n high (synced stage [1]) in any state:
  - fsm goes to IDLE the next cycle.
  - mm_m_re_o drops the next cycle; an ack arriving while re is low is ignored.
  - A partially shifted write word is discarded; no strobe is issued.
- States and transitions:
  - IDLE: clear counters, valid and MISO register. On CS_n fall (sync [2:1] = 10), go to CMD.
  - CMD: sample MOSI on each SCLK rise. After 1+MM_ADDR_WIDTH bits, latch the address into mm_m_addr_o, then:
    - write: go to WRITE;
    - read: assert mm_m_re_o the next cycle and go to DUMMY, or directly to READ if DUMMY_BITS = 0.
  - DUMMY: count DUMMY_BITS SCLK rises, ignore MOSI, then go to READ.
  - WRITE: shift in MOSI on SCLK rise. On the rise completing a word:
    - next cycle: mm_m_wdata_o = word, mm_m_we_o = 1 for one cycle, with mm_m_addr_o still holding the current address;
    - the cycle after the pulse: address += 1, wrapping modulo 2^MM_ADDR_WIDTH.
  - READ: MISO updates on SCLK fall.
    - The fall ending the final CMD/DUMMY bit loads the first word.
    - Each fall ending a word's last bit loads the next word.
    - Other falls shift the next bit out.
- Read handshake:
  - On a cycle with re = 1 and ack = 1: capture mm_m_rdata_i into the read buffer, set valid, drop re the next cycle.
  - Word load with valid = 1: shift register = buffer; clear valid; address += 1 (wrap); assert re the next cycle (prefetch of the new address).
  - Word load with valid = 0: shift register = DUMMY_DATA; spi_err_o pulses 1 cycle; re stays asserted; the next ack fills the buffer for the next word.
- Latency:
  - Write strobe: 2 clk_sys cycles after the synced SCLK rise of the last bit.
  - Read: the first ack must occur before the load edge; with DUMMY_BITS = 0 this gives about half an SCLK period.
- Simultaneous events:
  - Ack in the same cycle as the load edge: ack is taken first, so the load sees valid = 1 (buffer bypass) and there is no error.
  - CS_n rise in the same cycle as word completion: the write is discarded.

Test Plan:
1. Write burst (defaults): RW=0, addr 0x10, data 0x1234, 0x5678 -> we pulses with (addr 0x10, wdata 0x1234) then (0x11, 0x5678); exactly 2 pulses.
2. Address wrap: write at 0xFF with words 0xAAAA, 0x5555 -> pulses at addr 0xFF then 0x00.
3. Read burst, DUMMY_BITS = 4: addr 0x20; model acks 2 cycles after re with 0xBEEF (0x20) and 0xCAFE (0x21); 32 data clocks -> MISO = 0xBEEFCAFE MSB first, spi_err_o never asserted, re asserted for 0x20, 0x21, 0x22.
4. Underrun: read at 0x05, ack withheld -> MISO = DUMMY_DATA (0x0000), spi_err_o one pulse per unserved word; a late ack with 0x1111 is served as the next word.
5. Partial word / CS abort: write frame, CS_n rises after 10 data bits -> no we; a read aborted mid-handshake drops re within 4 clk_sys cycles and ignores a later ack.
6. Async reset asserted mid-read burst -> all outputs 0 immediately, fsm IDLE; the next full frame operates normally and MISO is high-Z whenever CS_n is high.

Source files
------------

// File: rtl/spi_slave_mm_burst.sv
// spi_slave_mm_burst
// SPI slave (mode 0, MSB first) bridging an external SPI host to an on-chip
// memory-mapped bus master. Frames are: 1 RW bit (1 = read), MM_ADDR_WIDTH
// address bits, optional DUMMY_BITS turnaround bits (reads only), then a burst
// of MM_DATA_WIDTH-bit words with address auto-increment until CS_n rises.
//
// Ports:
//   clk_sys_i, rst_n_i          system clock, async active-low reset
//   spi_sclk_i/mosi_i/cs_n_i    raw SPI pins (asynchronous, synchronised here)
//   spi_miso_o                  MISO, high-Z whenever the raw CS_n pin is high
//   mm_m_addr_o/wdata_o/we_o    bus address, write data, one-cycle write strobe
//   mm_m_re_o/ack_i/rdata_i     read request / acknowledge / read data
//   spi_err_o                   one-cycle pulse when a read word was not ready
//   dbg_state_o                 current FSM state, for observation only
//
// Read handshake: mm_m_re_o is held high with mm_m_addr_o stable until a cycle
// where mm_m_ack_i is also high; that cycle transfers mm_m_rdata_i and re drops
// on the next cycle. An ack seen while re is low transfers nothing. Writes have
// no back-pressure: the bus accepts in the single cycle mm_m_we_o is high.
module spi_slave_mm_burst #(
    parameter int                       MM_ADDR_WIDTH = 8,
    parameter int                       MM_DATA_WIDTH = 16,
    parameter int                       DUMMY_BITS    = 0,
    parameter logic [MM_DATA_WIDTH-1:0] DUMMY_DATA    = '0
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_n_i,
    input  logic                     spi_sclk_i,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    input  logic                     spi_cs_n_i,
    output logic [MM_ADDR_WIDTH-1:0] mm_m_addr_o,
    output logic [MM_DATA_WIDTH-1:0] mm_m_wdata_o,
    input  logic [MM_DATA_WIDTH-1:0] mm_m_rdata_i,
    output logic                     mm_m_we_o,
    output logic                     mm_m_re_o,
    input  logic                     mm_m_ack_i,
    output logic                     spi_err_o,
    output logic [2:0]               dbg_state_o
);

    localparam int AW       = MM_ADDR_WIDTH;
    localparam int DW       = MM_DATA_WIDTH;
    localparam int CMD_BITS = AW + 1;
    localparam int SR_W     = (CMD_BITS > DW) ? CMD_BITS : DW;
    localparam int MAX_A    = (CMD_BITS > DW) ? CMD_BITS : DW;
    localparam int MAX_CNT  = (MAX_A > DUMMY_BITS) ? MAX_A : DUMMY_BITS;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_DUMMY = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    logic [2:0]       sclk_sync_q, sclk_sync_d;
    logic [2:0]       cs_sync_q, cs_sync_d;
    logic [1:0]       mosi_sync_q, mosi_sync_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [SR_W-1:0]  rx_sr_q, rx_sr_d;
    logic [DW-1:0]    tx_sr_q, tx_sr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rbuf_q, rbuf_d;
    logic             rvalid_q, rvalid_d;
    logic             we_q, we_d;
    logic             re_q, re_d;
    logic             err_q, err_d;
    logic             miso_q, miso_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s, ack_take;

    assign sclk_rise = (sclk_sync_q[2:1] == 2'b01);
    assign sclk_fall = (sclk_sync_q[2:1] == 2'b10);
    assign cs_fall   = (cs_sync_q[2:1] == 2'b10);
    assign cs_high   = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign ack_take  = re_q & mm_m_ack_i;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk_i};
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n_i};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi_i};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rvalid_d    = rvalid_q;
        we_d        = 1'b0;
        re_d        = re_q;
        err_d       = 1'b0;
        miso_d      = miso_q;

        // The address steps only once the strobe has been seen by the bus.
        if (we_q) begin
            addr_d = addr_q + 1'b1;
        end

        // Capture comes first so a word load in the same cycle can bypass it.
        if (ack_take) begin
            rbuf_d   = mm_m_rdata_i;
            rvalid_d = 1'b1;
            re_d     = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            tx_sr_d   = '0;
            rvalid_d  = 1'b0;
            miso_d    = 1'b0;
        end

        if (cs_high) begin
            // Deselect aborts everything; a half-shifted word is simply dropped.
            state_d = ST_IDLE;
            re_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_sr_d = {rx_sr_q[SR_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                            bit_cnt_d = '0;
                            addr_d    = rx_sr_d[AW-1:0];
                            if (rx_sr_d[AW]) begin
                                re_d = 1'b1;
                                if (DUMMY_BITS == 0) begin
                                    state_d  = ST_READ;
                                    tx_cnt_d = CNT_W'(DW - 1);
                                end else begin
                                    state_d = ST_DUMMY;
                                end
                            end else begin
                                state_d = ST_WRITE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == CNT_W'(DUMMY_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = ST_READ;
                            // Primed as "last bit sent" so the next fall loads word 0.
                            tx_cnt_d  = CNT_W'(DW - 1);
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (sclk_rise) begin
                        rx_sr_d = {rx_sr_q[SR_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(DW - 1)) begin
                            bit_cnt_d = '0;
                            wdata_d   = rx_sr_d[DW-1:0];
                            we_d      = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        if (tx_cnt_q == CNT_W'(DW - 1)) begin
                            tx_cnt_d = '0;
                            if (rvalid_q || ack_take) begin
                                tx_sr_d  = rvalid_q ? rbuf_q : mm_m_rdata_i;
                                rvalid_d = 1'b0;
                                addr_d   = addr_q + 1'b1;
                                re_d     = 1'b1;
                            end else begin
                                // Underrun: re stays up so a late ack feeds the next word.
                                tx_sr_d = DUMMY_DATA;
                                err_d   = 1'b1;
                            end
                        end else begin
                            tx_sr_d  = tx_sr_q << 1;
                            tx_cnt_d = tx_cnt_q + 1'b1;
                        end
                        miso_d = tx_sr_d[DW-1];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_cnt_q    <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rvalid_q    <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            err_q       <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rvalid_q    <= rvalid_d;
            we_q        <= we_d;
            re_q        <= re_d;
            err_q       <= err_d;
            miso_q      <= miso_d;
        end
    end

    assign spi_miso_o   = spi_cs_n_i ? 1'bz : miso_q;
    assign mm_m_addr_o  = addr_q;
    assign mm_m_wdata_o = wdata_q;
    assign mm_m_we_o    = we_q;
    assign mm_m_re_o    = re_q;
    assign spi_err_o    = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spi_slave_mm_burst.sv
module tb_spi_slave_mm_burst;

    localparam int HALF = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, spi_sclk, spi_mosi, spi_cs_n;
    wire         miso_w;
    logic [7:0]  mm_addr;
    logic [15:0] mm_wdata, mm_rdata;
    logic        mm_we, mm_re, mm_ack, spi_err;
    logic [2:0]  dbg_state;

    pullup (miso_w);

    spi_slave_mm_burst #(
        .MM_ADDR_WIDTH(8),
        .MM_DATA_WIDTH(16),
        .DUMMY_BITS   (4),
        .DUMMY_DATA   (16'h0000)
    ) dut (
        .clk_sys_i   (clk),
        .rst_n_i     (rst_n),
        .spi_sclk_i  (spi_sclk),
        .spi_mosi_i  (spi_mosi),
        .spi_miso_o  (miso_w),
        .spi_cs_n_i  (spi_cs_n),
        .mm_m_addr_o (mm_addr),
        .mm_m_wdata_o(mm_wdata),
        .mm_m_rdata_i(mm_rdata),
        .mm_m_we_o   (mm_we),
        .mm_m_re_o   (mm_re),
        .mm_m_ack_i  (mm_ack),
        .spi_err_o   (spi_err),
        .dbg_state_o (dbg_state)
    );

    // ---------------- shared state ----------------
    int          tests_run = 0;
    int          fails = 0;
    logic [23:0] exp_q[$];      // expected {addr, wdata} write strobes
    logic [15:0] rd_exp_q[$];   // expected words seen on MISO
    logic [23:0] obs_q[$];      // observed write strobes (bus side)
    logic [7:0]  re_log[$];     // address at every rising edge of re
    logic [15:0] mem[256];
    int          err_cnt = 0;
    int          we_wide = 0;
    logic        ack_en = 1'b0;
    int          inject_req = 0;
    int          inject_done = 0;
    logic [15:0] inject_data = 16'h0;

    // ---------------- bus model + monitor ----------------
    initial begin
        logic we_prev, re_prev;
        int   wait_cnt;
        we_prev = 1'b0; re_prev = 1'b0; wait_cnt = 0;
        mm_ack = 1'b0; mm_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (mm_we) begin
                obs_q.push_back({mm_addr, mm_wdata});
                if (we_prev) we_wide++;
            end
            we_prev = mm_we;
            if (mm_re && !re_prev) re_log.push_back(mm_addr);
            re_prev = mm_re;
            if (spi_err) err_cnt++;
            if (mm_ack) begin
                mm_ack = 1'b0;
            end else if (inject_req != inject_done) begin
                mm_ack = 1'b1; mm_rdata = inject_data; inject_done++;
            end else if (mm_re && ack_en) begin
                if (wait_cnt == 1) begin
                    mm_ack = 1'b1; mm_rdata = mem[mm_addr]; wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic spi_xfer(input int nbits, input logic [63:0] tx, output logic [63:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso_w;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_stop();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic do_inject(input logic [15:0] data);
        inject_data = data;
        inject_req++;
        for (int k = 0; k < 10 && inject_done != inject_req; k++) @(negedge clk);
        tests_run++;
        if (inject_done != inject_req) begin
            fails++;
            $display("FAIL inject_timeout got done=%0d required %0d", inject_done, inject_req);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        tests_run += 7;
        if (mm_addr !== 8'h00)  begin fails++; $display("FAIL reset_addr got %h required 00", mm_addr); end
        if (mm_wdata !== 16'h0) begin fails++; $display("FAIL reset_wdata got %h required 0000", mm_wdata); end
        if (mm_we !== 1'b0)     begin fails++; $display("FAIL reset_we got %b required 0", mm_we); end
        if (mm_re !== 1'b0)     begin fails++; $display("FAIL reset_re got %b required 0", mm_re); end
        if (spi_err !== 1'b0)   begin fails++; $display("FAIL reset_err got %b required 0", spi_err); end
        if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d required 0", dbg_state); end
        if (miso_w !== 1'b1)    begin fails++; $display("FAIL reset_miso_hiz got %b required 1 (pulled)", miso_w); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write_burst();
        logic [63:0] rx;
        logic [23:0] exp, got;
        int          base;
        base = obs_q.size();
        exp_q.push_back({8'h10, 16'h1234});
        exp_q.push_back({8'h11, 16'h5678});
        frame_start();
        spi_xfer(41, {23'd0, 1'b0, 8'h10, 16'h1234, 16'h5678}, rx);
        frame_stop();
        tests_run++;
        if (obs_q.size() - base != 2) begin
            fails++; $display("FAIL write_burst_count got %0d required 2", obs_q.size() - base);
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = (base < obs_q.size()) ? obs_q[base] : 24'hxxxxxx;
            base++;
            tests_run++;
            if (got !== exp) begin fails++; $display("FAIL write_burst_strobe got %h required %h", got, exp); end
        end
        tests_run++;
        if (mm_addr !== 8'h12) begin fails++; $display("FAIL write_burst_addr_after got %h required 12", mm_addr); end
    endtask

    task automatic test_addr_wrap();
        logic [63:0] rx;
        logic [23:0] exp, got;
        int          base;
        base = obs_q.size();
        exp_q.push_back({8'hFF, 16'hAAAA});
        exp_q.push_back({8'h00, 16'h5555});
        frame_start();
        spi_xfer(41, {23'd0, 1'b0, 8'hFF, 16'hAAAA, 16'h5555}, rx);
        frame_stop();
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = (base < obs_q.size()) ? obs_q[base] : 24'hxxxxxx;
            base++;
            tests_run++;
            if (got !== exp) begin fails++; $display("FAIL wrap_strobe got %h required %h", got, exp); end
        end
        tests_run++;
        if (mm_addr !== 8'h01) begin fails++; $display("FAIL wrap_addr_after got %h required 01", mm_addr); end
    endtask

    task automatic test_read_burst();
        logic [63:0] rx;
        logic [15:0] exp, got;
        logic [7:0]  exp_re[3];
        int          err0, rbase;
        exp_re = '{8'h20, 8'h21, 8'h22};
        mem[8'h20] = 16'hBEEF; mem[8'h21] = 16'hCAFE; mem[8'h22] = 16'h0BAD;
        ack_en = 1'b1;
        err0 = err_cnt; rbase = re_log.size();
        rd_exp_q.push_back(16'hBEEF);
        rd_exp_q.push_back(16'hCAFE);
        frame_start();
        spi_xfer(45, {19'd0, 1'b1, 8'h20, 4'h0, 32'h0}, rx);
        frame_stop();
        for (int w = 1; w >= 0; w--) begin
            exp = rd_exp_q.pop_front();
            got = rx[w*16 +: 16];
            tests_run++;
            if (got !== exp) begin fails++; $display("FAIL read_word got %h required %h", got, exp); end
        end
        tests_run++;
        if (err_cnt - err0 != 0) begin fails++; $display("FAIL read_no_err got %0d pulses required 0", err_cnt - err0); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (rbase + k >= re_log.size()) begin
                fails++; $display("FAIL read_re_addr[%0d] got none required %h", k, exp_re[k]);
            end else if (re_log[rbase + k] !== exp_re[k]) begin
                fails++; $display("FAIL read_re_addr[%0d] got %h required %h", k, re_log[rbase + k], exp_re[k]);
            end
        end
        ack_en = 1'b0;
    endtask

    task automatic test_underrun();
        logic [63:0] rx, rxa, rxb, rxc;
        logic [15:0] exp, got;
        int          err0, rbase;
        ack_en = 1'b0;
        err0 = err_cnt; rbase = re_log.size();
        rd_exp_q.push_back(16'h0000);
        rd_exp_q.push_back(16'h1111);
        frame_start();
        spi_xfer(13, {51'd0, 1'b1, 8'h05, 4'h0}, rx);
        spi_xfer(8, 64'd0, rxa);
        do_inject(16'h1111);
        spi_xfer(8, 64'd0, rxb);
        spi_xfer(16, 64'd0, rxc);
        frame_stop();
        exp = rd_exp_q.pop_front(); got = {rxa[7:0], rxb[7:0]};
        tests_run++;
        if (got !== exp) begin fails++; $display("FAIL underrun_dummy_word got %h required %h", got, exp); end
        exp = rd_exp_q.pop_front(); got = rxc[15:0];
        tests_run++;
        if (got !== exp) begin fails++; $display("FAIL underrun_late_word got %h required %h", got, exp); end
        tests_run++;
        if (err_cnt - err0 != 2) begin fails++; $display("FAIL underrun_err_pulses got %0d required 2", err_cnt - err0); end
        tests_run++;
        if (re_log.size() - rbase != 2 || re_log[rbase] !== 8'h05 || re_log[rbase + 1] !== 8'h06) begin
            fails++; $display("FAIL underrun_re_addrs got %0d rises required 05,06", re_log.size() - rbase);
        end
    endtask

    task automatic test_cs_abort();
        logic [63:0] rx;
        logic [15:0] got;
        int          base, err0, k;
        // partial write word must not strobe
        base = obs_q.size();
        frame_start();
        spi_xfer(19, {45'd0, 1'b0, 8'h50, 10'h3FF}, rx);
        frame_stop();
        tests_run += 2;
        if (obs_q.size() != base) begin fails++; $display("FAIL abort_write_strobe got %0d required 0", obs_q.size() - base); end
        if (mm_addr !== 8'h50) begin fails++; $display("FAIL abort_write_addr got %h required 50", mm_addr); end
        // read aborted while re is pending
        ack_en = 1'b0;
        frame_start();
        spi_xfer(11, {53'd0, 1'b1, 8'h30, 2'b00}, rx);
        tests_run++;
        if (mm_re !== 1'b1) begin fails++; $display("FAIL abort_read_re_before got %b required 1", mm_re); end
        spi_cs_n = 1'b1;
        for (k = 0; k < 4 && mm_re !== 1'b0; k++) @(negedge clk);
        tests_run++;
        if (mm_re !== 1'b0) begin fails++; $display("FAIL abort_read_re_drop got %b required 0 within 4 cycles", mm_re); end
        do_inject(16'h7777);
        repeat (2 * HALF) @(negedge clk);
        // stray ack must not be served: next read underruns
        err0 = err_cnt;
        frame_start();
        spi_xfer(13, {51'd0, 1'b1, 8'h40, 4'h0}, rx);
        spi_xfer(16, 64'd0, rx);
        frame_stop();
        got = rx[15:0];
        tests_run += 2;
        if (got !== 16'h0000) begin fails++; $display("FAIL abort_stray_ack_word got %h required 0000", got); end
        if (err_cnt - err0 != 2) begin fails++; $display("FAIL abort_stray_ack_err got %0d required 2", err_cnt - err0); end
        tests_run++;
        if (we_wide != 0) begin fails++; $display("FAIL we_pulse_width got %0d wide pulses required 0", we_wide); end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] rx;
        logic [23:0] exp, got;
        int          base, err0;
        mem[8'h60] = 16'hFFFF; mem[8'h61] = 16'hFFFF; mem[8'h62] = 16'hFFFF;
        ack_en = 1'b1;
        frame_start();
        spi_xfer(18, {46'd0, 1'b1, 8'h60, 4'h0, 5'h00}, rx);
        tests_run += 2;
        if (miso_w !== 1'b1) begin fails++; $display("FAIL midread_miso_before got %b required 1", miso_w); end
        if (mm_addr !== 8'h61) begin fails++; $display("FAIL midread_addr_before got %h required 61", mm_addr); end
        #2 rst_n = 1'b0;
        #1;
        tests_run += 7;
        if (mm_addr !== 8'h00)  begin fails++; $display("FAIL midreset_addr got %h required 00", mm_addr); end
        if (mm_wdata !== 16'h0) begin fails++; $display("FAIL midreset_wdata got %h required 0000", mm_wdata); end
        if (mm_we !== 1'b0)     begin fails++; $display("FAIL midreset_we got %b required 0", mm_we); end
        if (mm_re !== 1'b0)     begin fails++; $display("FAIL midreset_re got %b required 0", mm_re); end
        if (spi_err !== 1'b0)   begin fails++; $display("FAIL midreset_err got %b required 0", spi_err); end
        if (dbg_state !== 3'd0) begin fails++; $display("FAIL midreset_state got %0d required 0", dbg_state); end
        if (miso_w !== 1'b0)    begin fails++; $display("FAIL midreset_miso got %b required 0", miso_w); end
        repeat (3) @(negedge clk);
        spi_cs_n = 1'b1;
        rst_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        tests_run++;
        if (miso_w !== 1'b1) begin fails++; $display("FAIL idle_miso_hiz got %b required 1 (pulled)", miso_w); end
        // full write frame after reset
        base = obs_q.size();
        exp_q.push_back({8'h70, 16'h0F0F});
        frame_start();
        spi_xfer(25, {39'd0, 1'b0, 8'h70, 16'h0F0F}, rx);
        frame_stop();
        exp = exp_q.pop_front();
        got = (base < obs_q.size()) ? obs_q[base] : 24'hxxxxxx;
        tests_run++;
        if (got !== exp) begin fails++; $display("FAIL postreset_write got %h required %h", got, exp); end
        // full read frame after reset
        mem[8'h70] = 16'h0F0F; mem[8'h71] = 16'h1234;
        err0 = err_cnt;
        rd_exp_q.push_back(16'h0F0F);
        frame_start();
        spi_xfer(29, {35'd0, 1'b1, 8'h70, 4'h0, 16'h0}, rx);
        frame_stop();
        tests_run += 2;
        if (rx[15:0] !== rd_exp_q[0]) begin fails++; $display("FAIL postreset_read got %h required %h", rx[15:0], rd_exp_q[0]); end
        void'(rd_exp_q.pop_front());
        if (err_cnt - err0 != 0) begin fails++; $display("FAIL postreset_err got %0d required 0", err_cnt - err0); end
        ack_en = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write_burst();
        test_addr_wrap();
        test_read_burst();
        test_underrun();
        test_cs_abort();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
